// File: rtl/alu_pkg.sv
// Shared types for the iterative execute-stage ALU: operation codes,
// control-FSM states, shift kinds and the shift-op classifier.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SRA = 4'b0111,
        ALU_EQ  = 4'b1000,
        ALU_XOR = 4'b1001,
        ALU_SLT = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shift_kind_e;

    // True for the three ops that go through the 1-bit/cycle shifter.
    function automatic logic is_shift(alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative shifter: holds the working value and remaining count, and moves
// one bit per step so no barrel shifter is needed.
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int SHAMT_W = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  step_i,
    input  shift_kind_e           kind_i,
    input  logic [DATA_WIDTH-1:0] src_i,
    input  logic [SHAMT_W-1:0]    shamt_i,
    output logic [SHAMT_W-1:0]    cnt_o,
    output logic [DATA_WIDTH-1:0] acc_nxt_o
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    logic [DATA_WIDTH-1:0] acc_q;
    logic [SHAMT_W-1:0]    cnt_q;
    shift_kind_e           kind_q;

    // Value after one more 1-bit shift of the working register.
    always_comb begin
        acc_nxt_o = acc_q;
        case (kind_q)
            SH_LL:   acc_nxt_o = {acc_q[DATA_WIDTH-2:0], 1'b0};
            SH_RL:   acc_nxt_o = {1'b0, acc_q[DATA_WIDTH-1:1]};
            SH_RA:   acc_nxt_o = {acc_q[DATA_WIDTH-1], acc_q[DATA_WIDTH-1:1]};
            default: acc_nxt_o = acc_q;
        endcase
    end

    // Count and shift kind are control state and return to a known value on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            kind_q <= SH_LL;
        end else if (load_i) begin
            cnt_q  <= shamt_i;
            kind_q <= kind_i;
        end else if (step_i) begin
            cnt_q  <= cnt_q - CNT_ONE;
        end
    end

    // Working value is pure data; it is always loaded before it is used.
    always_ff @(posedge clk) begin
        if (load_i) begin
            acc_q <= src_i;
        end else if (step_i) begin
            acc_q <= acc_nxt_o;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU with valid/ready on both sides. Single-cycle ops finish in
// one cycle; shifts are handed to alu_shift_unit and take shamt+1 cycles.
module alu_iter_exec
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int SHAMT_W = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  op_illegal
);

    alu_state_e            state_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;
    logic                  illegal_q;

    alu_op_e               op_e;
    logic [SHAMT_W-1:0]    shamt;
    logic                  op_shift;
    logic                  accept;
    logic [DATA_WIDTH-1:0] alu_res_d;
    logic                  alu_ill_d;
    shift_kind_e           kind_d;
    logic [SHAMT_W-1:0]    sh_cnt;
    logic [DATA_WIDTH-1:0] sh_nxt;

    assign op_e     = alu_op_e'(op);
    assign shamt    = src_b[SHAMT_W-1:0];
    assign op_shift = is_shift(op_e);
    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath; a shift yields src_a here, which is the answer for shamt==0.
    always_comb begin
        alu_res_d = '0;
        alu_ill_d = 1'b0;
        case (op_e)
            ALU_AND: alu_res_d = src_a & src_b;
            ALU_OR:  alu_res_d = src_a | src_b;
            ALU_ADD: alu_res_d = src_a + src_b;
            ALU_SUB: alu_res_d = src_a - src_b;
            ALU_XOR: alu_res_d = src_a ^ src_b;
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res_d = src_a;
            ALU_EQ:  alu_res_d[0] = (src_a == src_b);
            ALU_SLT: alu_res_d[0] = ($signed(src_a) < $signed(src_b));
            default: alu_ill_d = 1'b1;
        endcase
    end

    // Map the shift opcode onto the shifter's fill behaviour.
    always_comb begin
        kind_d = SH_LL;
        case (op_e)
            ALU_SRL: kind_d = SH_RL;
            ALU_SRA: kind_d = SH_RA;
            default: kind_d = SH_LL;
        endcase
    end

    alu_shift_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (accept && op_shift),
        .step_i    (state_q == SHIFT),
        .kind_i    (kind_d),
        .src_i     (src_a),
        .shamt_i   (shamt),
        .cnt_o     (sh_cnt),
        .acc_nxt_o (sh_nxt)
    );

    // Control FSM with registered result, flags and out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (op_shift && (shamt != '0)) begin
                            state_q <= SHIFT;
                        end else begin
                            result_q    <= alu_res_d;
                            zero_q      <= ~|alu_res_d;
                            illegal_q   <= alu_ill_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (sh_cnt == SHAMT_W'(1)) begin
                        result_q    <= sh_nxt;
                        zero_q      <= ~|sh_nxt;
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign zero       = zero_q;
    assign op_illegal = illegal_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Randomized and directed bench for alu_iter_exec against a behavioural model.
module tb_alu_iter_exec;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         op_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_iter_exec #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .op_illegal (op_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour straight from the operation table.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic ill, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        ill = 1'b0;
        lat = 1;
        case (o)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0011: r = a - b;
            4'b0100: begin r = a << sh; lat = sh + 1; end
            4'b0101: begin r = a >> sh; lat = sh + 1; end
            4'b0111: begin r = W'($signed(a) >>> sh); lat = sh + 1; end
            4'b1000: r = (a == b) ? 1 : 0;
            4'b1001: r = a ^ b;
            4'b1100: r = ($signed(a) < $signed(b)) ? 1 : 0;
            default: begin r = '0; ill = 1'b1; end
        endcase
    endfunction

    // Issue one op, measure latency, hold out_ready low for 'hold' cycles, then drain.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold, input bit noise);
        logic [W-1:0] er;
        logic         eill;
        int           elat;
        int           lat;
        bit           busy_ok;
        model(o, a, b, er, eill, elat);
        @(negedge clk);
        chk({tag, ".in_ready_idle"}, in_ready, 1);
        op = o; src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 64) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            if (noise) begin
                in_valid = 1'($urandom); op = 4'($urandom);
                src_a = $urandom; src_b = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({tag, ".busy_in_ready"}, busy_ok, 1);
        chk({tag, ".latency"}, lat, elat);
        chk({tag, ".result"}, result, er);
        chk({tag, ".zero"}, zero, (er == 0));
        chk({tag, ".illegal"}, op_illegal, eill);
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                in_valid = 1'($urandom); op = 4'($urandom);
                src_a = $urandom; src_b = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".hold_valid"}, out_valid, 1);
            chk({tag, ".hold_result"}, result, er);
            chk({tag, ".hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk({tag, ".drain_valid"}, out_valid, 0);
        chk({tag, ".drain_in_ready"}, in_ready, 1);
    endtask

    initial begin
        logic [3:0]   ro;
        logic [W-1:0] ra, rb;

        // Reset values
        #12;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.result", result, 0);
        chk("rst.zero", zero, 0);
        chk("rst.illegal", op_illegal, 0);
        chk("rst.in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 0, 0);
        run_op("sra4", 4'b0111, 32'h8000_0000, 32'h24, 0, 0);
        run_op("sll0", 4'b0100, 32'h1, 32'h0, 0, 0);
        run_op("slt_neg", 4'b1100, 32'hFFFF_FFFF, 32'h0, 0, 0);
        run_op("eq_bp", 4'b1000, 32'h1234, 32'h1234, 3, 0);
        run_op("illegal", 4'b0110, 32'h5, 32'h7, 0, 0);
        run_op("sll31", 4'b0100, 32'h1, 32'hFFFF_FFFF, 0, 0);

        // Reset in the middle of an SRL by 8
        @(negedge clk);
        op = 4'b0101; src_a = 32'hF0; src_b = 32'h8; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.result", result, 0);
        chk("midrst.zero", zero, 0);
        chk("midrst.illegal", op_illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst.in_ready", in_ready, 1);
        repeat (12) begin
            @(negedge clk);
            chk("midrst.no_result", out_valid, 0);
        end
        run_op("sub_after_rst", 4'b0011, 32'h3, 32'h5, 0, 0);

        // Randomized traffic, with junk driven while the unit is busy
        for (int n = 0; n < 60; n++) begin
            ro = 4'($urandom);
            if ($urandom_range(0, 2) == 0) ro = ($urandom_range(0, 1) == 0) ? 4'b0100 : 4'b0111;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 5) == 0) rb = '0;
            run_op("rand", ro, ra, rb, $urandom_range(0, 2), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
